free_list: RTL and testbench
============================

# free_list

Circular free list of physical register tags for the R10K-style rename stage. At dispatch it supplies new destination tags, the T that the map table is written with. At retirement it takes back each instruction's old tag (Told) and returns it to the pool. It keeps a speculative read pointer and an architectural read pointer, so a squash reclaims every tag allocated by in-flight instructions in one cycle. Depth is PHYS_REG_SZ − ARCH_REG_SZ entries: the number of tags not mapped by the architectural state.

## Interface
Parameters:
- PHYS_REG_SZ, default `PHYS_REG_SZ: number of physical registers.
- ARCH_REG_SZ, default 32: number of architectural registers.
- Derived: N = PHYS_REG_SZ − ARCH_REG_SZ (buffer depth), TW = $clog2(PHYS_REG_SZ) (tag width), PW = $clog2(N) (pointer index width).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted (low) forces the reset state immediately.
- alloc_req  in  1  dispatch requests one new tag this cycle.
- alloc_valid  out  1  high when free_count ≠ 0; an allocation fires only when alloc_req && alloc_valid.
- alloc_tag  out  TW  tag at the speculative head; combinational from current state; meaningful only when alloc_valid.
- retire_en  in  1  a retiring instruction with a destination register returns a tag this cycle.
- retire_told  in  TW  old tag being freed.
- squash  in  1  mispredict or exception recovery: discard all speculative allocations.
- free_count  out  PW+1  number of tags available to dispatch, range 0..N.

## Operation
- State:
  - buffer[N] of TW-bit tags.
  - Three pointers of PW+1 bits, the extra MSB being the wrap bit: spec_head, arch_head and tail.
  - free_count = tail − spec_head, computed modulo 2^(PW+1).
- Reset (reset low):
  - buffer[i] = ARCH_REG_SZ + i.
  - spec_head = arch_head = 0; tail = N (index 0 with the wrap bit set).
  - Outputs: free_count = N, alloc_valid = 1, alloc_tag = ARCH_REG_SZ.
- Allocate:
  - Fires when alloc_req && alloc_valid.
  - spec_head ← spec_head + 1.
  - alloc_tag is the pre-increment entry.
- Retire (retire_en):
  - buffer[tail index] ← retire_told.
  - tail ← tail + 1 and arch_head ← arch_head + 1.
  - Invariant: tail − arch_head = N always. The slot written is the retiring instruction's own allocated tag, which is now architecturally mapped, so the overwrite is safe.
- Squash: spec_head ← arch_head. The tags in the discarded region are still intact in the buffer.
- Simultaneous events:
  - Allocate + retire: both apply; free_count is unchanged.
  - Retire when free_count = 0: no allocation that cycle, because alloc_valid is computed from registered state (no bypass). The returned tag is visible next cycle.
  - Squash + allocate: squash wins; the allocation is dropped and spec_head does not advance.
  - Squash + retire: retire applies first (the retiring instruction is older and not squashed), so spec_head ← arch_head + 1.
- Illegal, flagged by assertion in simulation:
  - retire_en when spec_head = arch_head, i.e. no in-flight allocation exists.
  - alloc_req when alloc_valid = 0 is not an error; the request is simply ignored.

## Timing
- alloc_tag and alloc_valid are combinational from registered state: zero-cycle lookup. The pointer update takes effect on the next edge.
- A retired tag is allocatable starting the cycle after the retire_en edge.
- Squash takes one cycle. The cycle after, free_count = tail − arch_head (= N) and alloc_tag = buffer[arch_head].
- Reset is asynchronous: outputs reach reset values without a clock edge and hold them while reset is low. The first update happens on the first rising edge after reset goes high.
- Reset mid-operation discards all in-flight and retired state and restores tags ARCH_REG_SZ..PHYS_REG_SZ−1.
- Pointer arithmetic wraps modulo 2^(PW+1).
  - Full: spec_head = arch_head with free_count = N.
  - Empty: spec_head = tail.

## Test plan
Defaults: PHYS_REG_SZ = 64, ARCH_REG_SZ = 32, so N = 32.
- Release reset → alloc_valid = 1, alloc_tag = 32, free_count = 32.
- 32 back-to-back allocations → tags 32..63 in order; then free_count = 0 and alloc_valid = 0; a 33rd alloc_req is ignored and spec_head is unchanged.
- Retire while empty (state from the previous scenario), retire_told = 5 → next cycle alloc_valid = 1, alloc_tag = 5, free_count = 1; alloc_req held high in the retire cycle does not allocate.
- From reset: allocate 32, 33, 34; retire with told = 7; then squash → free_count = 32 and alloc_tag = 33; 32 further allocations yield 33..63 then 7.
- Concurrent events:
  - Allocate + retire at free_count = 1 → count stays 1.
  - Squash + alloc_req in the same cycle → no allocation, spec_head = arch_head.
  - Squash + retire → spec_head = arch_head + 1.
- Assert reset low asynchronously between clock edges mid-stream → outputs immediately show 32 / 1 / 32 (alloc_tag / alloc_valid / free_count) with no clock edge.

Source files
------------

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename-stage free list handshake bundle
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

interface free_list_if #(
   parameter int PHYS_REG_SZ = `PHYS_REG_SZ,
   parameter int ARCH_REG_SZ = 32
);
   localparam int N  = PHYS_REG_SZ - ARCH_REG_SZ;
   localparam int TW = $clog2(PHYS_REG_SZ);
   localparam int PW = $clog2(N);

   logic          alloc_req;
   logic          alloc_valid;
   logic [TW-1:0] alloc_tag;
   logic          retire_en;
   logic [TW-1:0] retire_told;
   logic          squash;
   logic [PW:0]   free_count;

   modport master (
      output alloc_req, retire_en, retire_told, squash,
      input  alloc_valid, alloc_tag, free_count
   );

   modport slave (
      input  alloc_req, retire_en, retire_told, squash,
      output alloc_valid, alloc_tag, free_count
   );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular physical tag free list with speculative and architectural heads
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module free_list #(
   parameter int PHYS_REG_SZ = `PHYS_REG_SZ,
   parameter int ARCH_REG_SZ = 32
) (
   input logic       clock,
   input logic       reset,
   free_list_if.slave bus
);
   localparam int N  = PHYS_REG_SZ - ARCH_REG_SZ;
   localparam int TW = $clog2(PHYS_REG_SZ);
   localparam int PW = $clog2(N);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   logic [TW-1:0] r_buffer [N];
   logic [PW:0]   r_spec_head;
   logic [PW:0]   r_arch_head;
   logic [PW:0]   r_tail;

   logic [PW:0]   w_free_count;
   logic          w_alloc_valid;
   logic          w_alloc_fire;
   logic [PW:0]   w_retire_inc;

   // Wrap bit distinguishes full (count N) from empty (count 0) at equal indices.
   assign w_free_count    = r_tail - r_spec_head;
   assign w_alloc_valid   = (w_free_count != '0);
   assign w_alloc_fire    = bus.alloc_req && w_alloc_valid && !bus.squash;
   assign w_retire_inc    = {{PW{1'b0}}, bus.retire_en};

   assign bus.free_count  = w_free_count;
   assign bus.alloc_valid = w_alloc_valid;
   assign bus.alloc_tag   = r_buffer[r_spec_head[PW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            r_buffer[i] <= TW'(ARCH_REG_SZ + i);
         end
         r_spec_head <= '0;
         r_arch_head <= '0;
         r_tail      <= (PW+1)'(N);
      end else begin
         // The tail slot holds the retiring instruction's own tag, now architecturally mapped.
         if (bus.retire_en) begin
            r_buffer[r_tail[PW-1:0]] <= bus.retire_told;
            r_tail                   <= r_tail + PTR_ONE;
            r_arch_head              <= r_arch_head + PTR_ONE;
         end
         if (bus.squash) begin
            r_spec_head <= r_arch_head + w_retire_inc;
         end else if (w_alloc_fire) begin
            r_spec_head <= r_spec_head + PTR_ONE;
         end
      end
   end

   a_retire_needs_inflight: assert property (
      @(posedge clock) disable iff (!reset)
      !(bus.retire_en && (r_spec_head == r_arch_head))
   );

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list against a tag-pool queue model
module tb_free_list;
   localparam int PHYS = 64;
   localparam int ARCH = 32;
   localparam int N    = PHYS - ARCH;

   typedef struct {
      logic       valid;
      logic [5:0] tag;
      logic [5:0] count;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   free_list_if #(.PHYS_REG_SZ(PHYS), .ARCH_REG_SZ(ARCH)) bus ();

   free_list #(.PHYS_REG_SZ(PHYS), .ARCH_REG_SZ(ARCH)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   exp_t exp_q[$];
   int   free_q[$];
   int   infl_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Free tags in allocation order, and allocated-but-unretired tags oldest first.
   task automatic model_reset();
      free_q.delete();
      infl_q.delete();
      for (int i = 0; i < N; i++) free_q.push_back(ARCH + i);
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.count = 6'(free_q.size());
      e.valid = (free_q.size() != 0);
      e.tag   = e.valid ? 6'(free_q[0]) : 6'd0;
      return e;
   endfunction

   task automatic model_step(input bit a, input bit r, input int told, input bit s);
      bit fire;
      int t;
      fire = a && (free_q.size() != 0) && !s;
      t = 0;
      if (fire) t = free_q.pop_front();
      if (r) begin
         void'(infl_q.pop_front());
         free_q.push_back(told);
      end
      if (fire) infl_q.push_back(t);
      if (s) begin
         for (int i = infl_q.size() - 1; i >= 0; i--) free_q.push_front(infl_q[i]);
         infl_q.delete();
      end
   endtask

   task automatic cycle(input bit a, input bit r, input int told, input bit s);
      exp_t e;
      bus.alloc_req   = a;
      bus.retire_en   = r;
      bus.retire_told = 6'(told);
      bus.squash      = s;
      model_step(a, r, told, s);
      e = model_out();
      @(posedge clock);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alloc_req   = 1'b0;
      bus.retire_en   = 1'b0;
      bus.retire_told = 6'd0;
      bus.squash      = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tag"},   32'(bus.alloc_tag),   32'd32);
      chk({tag, "_valid"}, 32'(bus.alloc_valid), 32'd1);
      chk({tag, "_count"}, 32'(bus.free_count),  32'd32);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_valid", 32'(bus.alloc_valid), 32'(e.valid));
            chk("sb_count", 32'(bus.free_count),  32'(e.count));
            if (e.valid) chk("sb_tag", 32'(bus.alloc_tag), 32'(e.tag));
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      bit a, r, s;
      idle_inputs();
      #12;
      chk_reset_outputs("reset");
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Drain the pool, then one ignored request.
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, 0, 1'b0);
      chk("empty_count", 32'(bus.free_count), 32'd0);
      chk("empty_valid", 32'(bus.alloc_valid), 32'd0);
      cycle(1'b1, 1'b0, 0, 1'b0);

      // Retire while empty with alloc_req held: no allocation that cycle.
      cycle(1'b1, 1'b1, 5, 1'b0);
      chk("ret_empty_tag",   32'(bus.alloc_tag),   32'd5);
      chk("ret_empty_count", 32'(bus.free_count),  32'd1);
      chk("ret_empty_valid", 32'(bus.alloc_valid), 32'd1);

      cycle(1'b1, 1'b1, 9, 1'b0);
      chk("alloc_retire_count", 32'(bus.free_count), 32'd1);

      cycle(1'b1, 1'b0, 0, 1'b1);
      chk("squash_alloc_count", 32'(bus.free_count), 32'd32);

      cycle(1'b1, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b1, 11, 1'b1);
      chk("squash_retire_count", 32'(bus.free_count), 32'd32);

      // Asynchronous reset between edges.
      cycle(1'b1, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      model_reset();
      @(posedge clock);
      #1;
      chk_reset_outputs("reset_hold");
      idle_inputs();
      reset = 1'b1;

      cycle(1'b1, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b1, 7, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b1);
      chk("squash_count", 32'(bus.free_count), 32'd32);
      chk("squash_tag",   32'(bus.alloc_tag),  32'd33);
      for (int i = 0; i < N - 1; i++) cycle(1'b1, 1'b0, 0, 1'b0);
      chk("wrap_tag7", 32'(bus.alloc_tag), 32'd7);
      cycle(1'b1, 1'b0, 0, 1'b0);
      chk("refill_empty", 32'(bus.free_count), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         a = ($urandom_range(0, 9) < 6);
         r = (infl_q.size() != 0) && ($urandom_range(0, 1) == 1);
         s = ($urandom_range(0, 19) == 0);
         cycle(a, r, int'($urandom_range(0, 63)), s);
      end

      idle_inputs();
      @(posedge clock);
      #3;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
